// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, special encodings and sequencer state encoding.
package fp16_pkg;

    localparam int FP_EXP_W  = 5;
    localparam int FP_MANT_W = 11;
    localparam int FP_FRAC_W = 10;

    localparam logic [4:0]  EXP_BIAS  = 5'd15;
    localparam logic [4:0]  EXP_MAX   = 5'd31;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [14:0] FP16_INF  = 15'h7C00;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    function automatic logic [15:0] fp16_pack(input logic                 sign,
                                              input logic [FP_EXP_W-1:0]  expo,
                                              input logic [FP_FRAC_W-1:0] frac);
        return {sign, expo, frac};
    endfunction

endpackage

// File: rtl/mant_addsub11.sv
// 11-bit ripple-carry mantissa adder/subtractor; purely combinational.
// sum_add=1 selects A-B (B inverted, carry-in set), otherwise A+B.
module mant_addsub11
    import fp16_pkg::*;
(
    input  logic [FP_MANT_W-1:0] A,
    input  logic [FP_MANT_W-1:0] B,
    input  logic                 sum_add,
    output logic [FP_MANT_W-1:0] S,
    output logic                 Cout
);

    logic [FP_MANT_W-1:0] w_b_x;
    logic                 w_c;

    assign w_b_x = B ^ {FP_MANT_W{sum_add}};

    always_comb begin
        w_c = sum_add;
        S   = '0;
        for (int i = 0; i < FP_MANT_W; i++) begin
            S[i] = A[i] ^ w_b_x[i] ^ w_c;
            w_c  = (A[i] & w_b_x[i]) | (w_c & (A[i] ^ w_b_x[i]));
        end
        Cout = w_c;
    end

endmodule

// File: rtl/fp16_add_sequencer.sv
// Multi-cycle FP16 add/sub (truncating, subnormals flushed) on one shared 11-bit mantissa unit.
// Latency 1 for inf/NaN operands, else 2 + align + normalize cycles; one op in flight, result held until out_ready.
module fp16_add_sequencer
    import fp16_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        op_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_nan
);

    logic [15:0]       w_b_in;
    logic [15:0]       w_big;
    logic [15:0]       w_small;
    logic              w_swap;
    logic [EXP_W-1:0]  w_big_exp;
    logic [EXP_W-1:0]  w_small_exp;
    logic              w_a_max;
    logic              w_b_max;
    logic              w_special;
    logic              w_spec_nan;
    logic [15:0]       w_spec_result;
    logic [MANT_W-1:0] w_s;
    logic              w_cout;
    logic              w_norm_lead;
    logic [MANT_W-2:0] w_norm_frac;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [15:0]       r_result;
    logic              r_flag_ovf;
    logic              r_flag_unf;
    logic              r_flag_nan;
    logic              r_sign;
    logic              r_sub;
    logic [EXP_W-1:0]  r_exp;
    logic [EXP_W-1:0]  r_d;
    logic [MANT_W-1:0] r_ma;
    logic [MANT_W-1:0] r_mb;
    // hidden bit is known to be 0 while normalizing, so only the fraction is kept
    logic [MANT_W-2:0] r_frac;

    assign w_b_in      = {b[15] ^ op_sub, b[14:0]};
    assign w_swap      = (w_b_in[14:0] > a[14:0]);
    assign w_big       = w_swap ? w_b_in : a;
    assign w_small     = w_swap ? a : w_b_in;
    assign w_big_exp   = w_big[FP_FRAC_W +: EXP_W];
    assign w_small_exp = w_small[FP_FRAC_W +: EXP_W];

    assign w_a_max       = (a[FP_FRAC_W +: EXP_W] == EXP_MAX);
    assign w_b_max       = (b[FP_FRAC_W +: EXP_W] == EXP_MAX);
    assign w_special     = w_a_max | w_b_max;
    assign w_spec_nan    = (w_a_max && (a[FP_FRAC_W-1:0] != '0))
                         || (w_b_max && (b[FP_FRAC_W-1:0] != '0))
                         || (w_a_max && w_b_max && (a[15] != w_b_in[15]));
    assign w_spec_result = w_spec_nan ? FP16_QNAN
                         : (w_a_max ? {a[15], FP16_INF} : {w_b_in[15], FP16_INF});

    assign w_norm_lead = r_frac[MANT_W-2];
    assign w_norm_frac = {r_frac[MANT_W-3:0], 1'b0};

    mant_addsub11 u_mant_addsub (
        .A       (r_ma),
        .B       (r_mb),
        .sum_add (r_sub),
        .S       (w_s),
        .Cout    (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag_ovf  <= 1'b0;
            r_flag_unf  <= 1'b0;
            r_flag_nan  <= 1'b0;
            r_sign      <= 1'b0;
            r_sub       <= 1'b0;
            r_exp       <= '0;
            r_d         <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_frac      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_flag_ovf <= 1'b0;
                        r_flag_unf <= 1'b0;
                        r_flag_nan <= 1'b0;
                        if (w_special) begin
                            r_result    <= w_spec_result;
                            r_flag_nan  <= w_spec_nan;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_sign  <= w_big[15];
                            r_sub   <= w_big[15] ^ w_small[15];
                            r_exp   <= w_big_exp;
                            r_d     <= w_big_exp - w_small_exp;
                            r_ma    <= {w_big_exp != '0, w_big[FP_FRAC_W-1:0]};
                            r_mb    <= {w_small_exp != '0, w_small[FP_FRAC_W-1:0]};
                            r_state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (r_d == '0 || r_mb == '0) begin
                        r_state <= ADD;
                    end else if (r_d >= 5'd11) begin
                        r_mb    <= '0;
                        r_state <= ADD;
                    end else begin
                        r_mb <= r_mb >> 1;
                        r_d  <= r_d - 5'd1;
                        if (r_d == 5'd1) begin
                            r_state <= ADD;
                        end
                    end
                end
                ADD: begin
                    r_frac <= w_s[MANT_W-2:0];
                    if (!r_sub && w_cout) begin
                        if (r_exp == EXP_MAX - 5'd1) begin
                            r_result   <= {r_sign, FP16_INF};
                            r_flag_ovf <= 1'b1;
                        end else begin
                            r_exp    <= r_exp + 5'd1;
                            r_result <= fp16_pack(r_sign, r_exp + 5'd1, w_s[MANT_W-1:1]);
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_s == '0) begin
                        // exact cancellation is +0; a plain add only reaches here for 0+0
                        r_result    <= {r_sign & ~r_sub, 15'h0};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_s[MANT_W-1]) begin
                        r_result    <= fp16_pack(r_sign, r_exp, w_s[MANT_W-2:0]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (r_exp <= 5'd1) begin
                        r_result    <= {r_sign, 15'h0};
                        r_flag_unf  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_frac <= w_norm_frac;
                        r_exp  <= r_exp - 5'd1;
                        if (w_norm_lead) begin
                            r_result    <= fp16_pack(r_sign, r_exp - 5'd1, w_norm_frac);
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (r_exp == 5'd2) begin
                            r_result    <= {r_sign, 15'h0};
                            r_flag_unf  <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_ovf  = r_flag_ovf;
    assign flag_unf  = r_flag_unf;
    assign flag_nan  = r_flag_nan;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// Scoreboard bench for fp16_add_sequencer: directed vectors push expectations, a negedge monitor checks them.
module tb_fp16_add_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_nan;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic [2:0]  flags;   // {ovf, unf, nan}
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    bit   seen    = 1'b0;

    fp16_add_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_nan  (flag_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Monitor: pops one expectation per completed output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out_valid: got result %0h, want no output", result);
                end else begin
                    cur = q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        check($sformatf("op%0d latency", cur.id), cyc - acc_cyc, cur.lat);
                    end
                    check($sformatf("op%0d result", cur.id), 32'(result), 32'(cur.res));
                    check($sformatf("op%0d flags", cur.id), 32'({flag_ovf, flag_unf, flag_nan}),
                          32'(cur.flags));
                    check($sformatf("op%0d in_ready_busy", cur.id), 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input int id, input logic [15:0] va, input logic [15:0] vb,
                         input logic sub, input logic [15:0] er, input logic [2:0] ef,
                         input int el, input bit push);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("op%0d in_ready_wait", id), 32'(in_ready), 32'd1);
        if (in_ready) begin
            a        = va;
            b        = vb;
            op_sub   = sub;
            in_valid = 1'b1;
            if (push) q.push_back('{id, er, ef, el});
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", q.size(), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst result", 32'(result), 32'd0);
        check("rst flags", 32'({flag_ovf, flag_unf, flag_nan}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //    id  a         b         sub   result    {o,u,n}  lat
        issue(1,  16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000,  3,  1'b1);
        issue(2,  16'h3E00, 16'h3C00, 1'b1, 16'h3800, 3'b000,  4,  1'b1);
        issue(3,  16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100,  3,  1'b1);
        issue(4,  16'h3C00, 16'hBC00, 1'b0, 16'h0000, 3'b000,  3,  1'b1);
        issue(5,  16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b000,  3,  1'b1);
        issue(6,  16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b001,  1,  1'b1);
        issue(7,  16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000,  1,  1'b1);
        issue(8,  16'h4000, 16'h3C00, 1'b0, 16'h4200, 3'b000,  3,  1'b1);
        issue(9,  16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000,  3,  1'b1);
        issue(10, 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000,  3,  1'b1);
        issue(11, 16'h3C00, 16'h2C00, 1'b0, 16'h3C40, 3'b000,  6,  1'b1);
        issue(12, 16'h3C01, 16'h3C00, 1'b1, 16'h1400, 3'b000,  13, 1'b1);
        issue(13, 16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b010,  4,  1'b1);
        issue(14, 16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000,  4,  1'b1);
        issue(15, 16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b001,  1,  1'b1);
        issue(16, 16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b000,  3,  1'b1);
        issue(17, 16'hFC00, 16'h7C00, 1'b1, 16'hFC00, 3'b000,  1,  1'b1);
        wait_drain();

        // Consumer stalls for 5 cycles with the result pending.
        out_ready = 1'b0;
        issue(18, 16'h4000, 16'h4000, 1'b0, 16'h4400, 3'b000, 3, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("hold out_valid", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold result", 32'(result), 32'h4400);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        wait_drain();

        // Abort an operation while it is still aligning (d=4).
        issue(19, 16'h3C00, 16'h2C00, 1'b0, 16'h3C40, 3'b000, 6, 1'b0);
        @(posedge clk); #1;
        check("pre-abort in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(20, 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000, 3, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
